// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: integer + fractional divisor with shadowed update,
// oversample and bit strobes, and a registered square wave for the BAUDOUT pin.
module baud_gen_frac #(
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned FRAC_WIDTH = 4,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned RESET_DIV  = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [DIV_WIDTH-1:0]  DIVISOR,
    input  logic [FRAC_WIDTH-1:0] FRAC,
    input  logic                  DIV_LOAD,
    input  logic                  SYNC_CLR,
    output logic                  BAUD_TICK,
    output logic                  BIT_TICK,
    output logic                  BAUDOUT_CLK,
    output logic                  DIV_PENDING
);

    localparam int unsigned        OsW      = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OsW-1:0]     OsLast   = OsW'(OVERSAMPLE - 1);
    localparam logic [OsW-1:0]     OsOne    = OsW'(1);
    localparam logic [DIV_WIDTH:0] NOne     = (DIV_WIDTH + 1)'(1);
    localparam logic [DIV_WIDTH-1:0] CntOne = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] ResetDiv = DIV_WIDTH'(RESET_DIV);

    logic [DIV_WIDTH-1:0]  d_q, d_d;
    logic [FRAC_WIDTH-1:0] f_q, f_d;
    logic [DIV_WIDTH-1:0]  sh_div_q, sh_div_d;
    logic [FRAC_WIDTH-1:0] sh_frac_q, sh_frac_d;
    logic                  pend_q, pend_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [FRAC_WIDTH-1:0] acc_q, acc_d;
    logic                  ext_q, ext_d;
    logic [OsW-1:0]        os_q, os_d;
    logic                  en_q, en_d;
    logic                  tick_q, tick_d;
    logic                  bit_q, bit_d;
    logic                  bclk_q, bclk_d;

    logic                  halt;
    logic                  active;
    logic                  wrap;
    logic                  apply;
    logic [DIV_WIDTH:0]    n;
    logic [DIV_WIDTH:0]    half;
    logic [FRAC_WIDTH:0]   acc_sum;

    always_comb begin
        halt    = !EN || (d_q == '0);
        // en_q gives one idle start-up cycle (CNT=0) after EN rises.
        active  = !halt && en_q;
        n       = {1'b0, d_q} + {{DIV_WIDTH{1'b0}}, ext_q};
        half    = (n + NOne) >> 1;
        wrap    = active && !SYNC_CLR && ({1'b0, cnt_q} == (n - NOne));
        acc_sum = {1'b0, acc_q} + {1'b0, f_q};
        apply   = pend_q && (halt || (active && (SYNC_CLR || wrap)));
    end

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        ext_d  = ext_q;
        os_d   = os_q;
        tick_d = 1'b0;
        bit_d  = 1'b0;
        bclk_d = 1'b0;
        en_d   = EN;

        if (!active) begin
            cnt_d = '0;
            acc_d = '0;
            ext_d = 1'b0;
            os_d  = '0;
        end else if (SYNC_CLR) begin
            cnt_d  = '0;
            acc_d  = '0;
            ext_d  = 1'b0;
            os_d   = '0;
            bclk_d = ({1'b0, cnt_q} < half);
        end else if (wrap) begin
            cnt_d  = '0;
            acc_d  = acc_sum[FRAC_WIDTH-1:0];
            ext_d  = acc_sum[FRAC_WIDTH];
            os_d   = (os_q == OsLast) ? '0 : os_q + OsOne;
            tick_d = 1'b1;
            bit_d  = (os_q == OsLast);
            bclk_d = ({1'b0, cnt_q} < half);
        end else begin
            cnt_d  = cnt_q + CntOne;
            bclk_d = ({1'b0, cnt_q} < half);
        end
    end

    always_comb begin
        d_d       = d_q;
        f_d       = f_q;
        sh_div_d  = sh_div_q;
        sh_frac_d = sh_frac_q;
        pend_d    = pend_q;

        if (apply) begin
            d_d    = sh_div_q;
            f_d    = sh_frac_q;
            pend_d = 1'b0;
        end

        // While halted there is no period boundary to wait for, so load straight through.
        if (DIV_LOAD) begin
            sh_div_d  = DIVISOR;
            sh_frac_d = FRAC;
            if (halt) begin
                d_d    = DIVISOR;
                f_d    = FRAC;
                pend_d = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            d_q       <= ResetDiv;
            f_q       <= '0;
            sh_div_q  <= '0;
            sh_frac_q <= '0;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            ext_q     <= 1'b0;
            os_q      <= '0;
            en_q      <= 1'b0;
            tick_q    <= 1'b0;
            bit_q     <= 1'b0;
            bclk_q    <= 1'b0;
        end else begin
            d_q       <= d_d;
            f_q       <= f_d;
            sh_div_q  <= sh_div_d;
            sh_frac_q <= sh_frac_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            ext_q     <= ext_d;
            os_q      <= os_d;
            en_q      <= en_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            bclk_q    <= bclk_d;
        end
    end

    assign BAUD_TICK   = tick_q;
    assign BIT_TICK    = bit_q;
    assign BAUDOUT_CLK = bclk_q;
    assign DIV_PENDING = pend_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: tick timing, fractional spacing, shadow update,
// realign, enable/reset recovery and divisor edge cases.
module tb_baud_gen_frac;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b1;
    logic        DIV_LOAD = 1'b0;
    logic        SYNC_CLR = 1'b0;
    logic [15:0] DIVISOR = '0;
    logic [3:0]  FRAC = '0;
    logic        BAUD_TICK;
    logic        BIT_TICK;
    logic        BAUDOUT_CLK;
    logic        DIV_PENDING;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 CLK = ~CLK;

    baud_gen_frac dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .DIVISOR    (DIVISOR),
        .FRAC       (FRAC),
        .DIV_LOAD   (DIV_LOAD),
        .SYNC_CLR   (SYNC_CLR),
        .BAUD_TICK  (BAUD_TICK),
        .BIT_TICK   (BIT_TICK),
        .BAUDOUT_CLK(BAUDOUT_CLK),
        .DIV_PENDING(DIV_PENDING)
    );

    // Outputs are read 1 time unit after the rising edge; cyc numbers that edge.
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        RST = 1'b1; EN = 1'b1; DIV_LOAD = 1'b0; SYNC_CLR = 1'b0;
        step();
        RST = 1'b0;
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] f);
        DIVISOR = d; FRAC = f; DIV_LOAD = 1'b1;
        step();
        DIV_LOAD = 1'b0;
    endtask

    task automatic wait_tick(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (BAUD_TICK) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        RST = 1'b1; EN = 1'b1;
        step(); step();
        n_run++;
        if ({BAUD_TICK, BIT_TICK, BAUDOUT_CLK, DIV_PENDING} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0000",
                     {BAUD_TICK, BIT_TICK, BAUDOUT_CLK, DIV_PENDING});
        end
        RST = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if ({BAUD_TICK, BIT_TICK, BAUDOUT_CLK, DIV_PENDING} !== 4'b0000) bad++;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_div0_halted: %0d active cycles, want 0", bad);
        end
    endtask

    task automatic test_basic();
        int l;
        logic [2:0] exp_v;
        logic et, eb, ec;
        do_reset();
        l = cyc;
        load(16'd4, 4'd0);
        n_run++;
        if (DIV_PENDING !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_no_pending: got %b want 0", DIV_PENDING);
        end
        for (int i = 0; i < 80; i++) begin
            et = (cyc >= l + 5) && (((cyc - l - 5) % 4) == 0);
            eb = et && ((((cyc - l - 5) / 4) % 16) == 15);
            ec = (cyc >= l + 2) && (((cyc - l - 2) % 4) < 2);
            exp_v = {et, eb, ec};
            n_run++;
            if ({BAUD_TICK, BIT_TICK, BAUDOUT_CLK} !== exp_v) begin
                n_fail++;
                $display("FAIL basic_div4 cyc+%0d: tick/bit/clk got %b want %b",
                         cyc - l, {BAUD_TICK, BIT_TICK, BAUDOUT_CLK}, exp_v);
            end
            step();
        end
    endtask

    task automatic test_frac();
        int l, t, first, prev;
        int exp_sp[8];
        exp_sp = '{4, 4, 4, 5, 4, 4, 4, 5};
        do_reset();
        l = cyc;
        load(16'd4, 4'd4);
        wait_tick(t);
        n_run++;
        if (t != l + 5) begin
            n_fail++;
            $display("FAIL frac_first_tick: got cyc+%0d want cyc+5", t - l);
        end
        first = t;
        prev  = t;
        for (int k = 0; k < 8; k++) begin
            wait_tick(t);
            n_run++;
            if (t - prev != exp_sp[k]) begin
                n_fail++;
                $display("FAIL frac_spacing[%0d]: got %0d want %0d", k, t - prev, exp_sp[k]);
            end
            prev = t;
        end
        for (int k = 8; k < 64; k++) begin
            wait_tick(t);
            prev = t;
        end
        n_run++;
        if (prev - first != 272) begin
            n_fail++;
            $display("FAIL frac_64_ticks_span: got %0d want 272", prev - first);
        end
    endtask

    task automatic test_pending();
        int l, t, t2, bad;
        do_reset();
        l = cyc;
        load(16'd10, 4'd0);
        wait_tick(t);
        n_run++;
        if (t != l + 11) begin
            n_fail++;
            $display("FAIL pend_first_tick: got cyc+%0d want cyc+11", t - l);
        end
        step(); step(); step();
        DIVISOR = 16'd7; DIV_LOAD = 1'b1;
        step();
        n_run++;
        if (DIV_PENDING !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_set: got %b want 1", DIV_PENDING);
        end
        DIVISOR = 16'd3;
        step();
        DIV_LOAD = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (DIV_PENDING !== 1'b1 || BAUD_TICK !== 1'b0) bad++;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL pend_hold: %0d bad cycles, want 0", bad);
        end
        step();
        n_run++;
        if ({BAUD_TICK, DIV_PENDING} !== 2'b10 || cyc != t + 10) begin
            n_fail++;
            $display("FAIL pend_wrap: tick/pend got %b at +%0d want 10 at +10",
                     {BAUD_TICK, DIV_PENDING}, cyc - t);
        end
        t = cyc;
        wait_tick(t2);
        n_run++;
        if (t2 - t != 3) begin
            n_fail++;
            $display("FAIL pend_new_period1: got %0d want 3", t2 - t);
        end
        t = t2;
        wait_tick(t2);
        n_run++;
        if (t2 - t != 3) begin
            n_fail++;
            $display("FAIL pend_new_period2: got %0d want 3", t2 - t);
        end
    endtask

    task automatic test_sync_clr();
        int l, t, tt, first_tt, bt_cyc, idx;
        do_reset();
        l = cyc;
        load(16'd4, 4'd0);
        wait_tick(t);
        step(); step(); step();
        SYNC_CLR = 1'b1;
        step();
        SYNC_CLR = 1'b0;
        n_run++;
        if (BAUD_TICK !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_no_tick: got %b want 0", BAUD_TICK);
        end
        first_tt = -1; bt_cyc = -1; idx = 0;
        for (int i = 1; i <= 20; i++) begin
            wait_tick(tt);
            if (i == 1) first_tt = tt;
            if (BIT_TICK && bt_cyc < 0) begin
                bt_cyc = tt;
                idx = i;
            end
        end
        n_run++;
        if (first_tt != t + 8) begin
            n_fail++;
            $display("FAIL sync_next_tick: got +%0d want +8", first_tt - t);
        end
        n_run++;
        if (idx != 16 || bt_cyc != t + 68) begin
            n_fail++;
            $display("FAIL sync_bit_tick: got tick #%0d at +%0d want #16 at +68",
                     idx, bt_cyc - t);
        end
    endtask

    task automatic test_en_restart();
        int t, c, t2;
        do_reset();
        load(16'd4, 4'd0);
        wait_tick(t);
        step();
        n_run++;
        if (BAUDOUT_CLK !== 1'b1) begin
            n_fail++;
            $display("FAIL en_clk_high_before: got %b want 1", BAUDOUT_CLK);
        end
        EN = 1'b0;
        step();
        n_run++;
        if ({BAUD_TICK, BIT_TICK, BAUDOUT_CLK} !== 3'b000) begin
            n_fail++;
            $display("FAIL en_drop_outputs: got %b want 000", {BAUD_TICK, BIT_TICK, BAUDOUT_CLK});
        end
        step(); step();
        load(16'd6, 4'd0);
        n_run++;
        if (DIV_PENDING !== 1'b0) begin
            n_fail++;
            $display("FAIL en_low_load_applied: pending got %b want 0", DIV_PENDING);
        end
        step();
        EN = 1'b1;
        c = cyc;
        wait_tick(t2);
        n_run++;
        if (t2 != c + 7) begin
            n_fail++;
            $display("FAIL en_restart_tick: got +%0d want +7", t2 - c);
        end
        t = t2;
        wait_tick(t2);
        n_run++;
        if (t2 - t != 6) begin
            n_fail++;
            $display("FAIL en_restart_spacing: got %0d want 6", t2 - t);
        end
    endtask

    task automatic test_rst_mid();
        int t, bad;
        do_reset();
        load(16'd4, 4'd0);
        wait_tick(t);
        DIVISOR = 16'd9; DIV_LOAD = 1'b1;
        step();
        DIV_LOAD = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        n_run++;
        if ({BAUD_TICK, BIT_TICK, BAUDOUT_CLK, DIV_PENDING} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %b want 0000",
                     {BAUD_TICK, BIT_TICK, BAUDOUT_CLK, DIV_PENDING});
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if ({BAUD_TICK, BAUDOUT_CLK, DIV_PENDING} !== 3'b000) bad++;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_mid_stays_halted: %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_div1_div0();
        int l, c, bad;
        logic [2:0] exp_v;
        do_reset();
        l = cyc;
        load(16'd1, 4'd0);
        for (int i = 0; i < 40; i++) begin
            exp_v = {cyc >= l + 2, (cyc == l + 17) || (cyc == l + 33), cyc >= l + 2};
            n_run++;
            if ({BAUD_TICK, BIT_TICK, BAUDOUT_CLK} !== exp_v) begin
                n_fail++;
                $display("FAIL div1 cyc+%0d: tick/bit/clk got %b want %b",
                         cyc - l, {BAUD_TICK, BIT_TICK, BAUDOUT_CLK}, exp_v);
            end
            step();
        end
        c = cyc;
        DIVISOR = 16'd0; DIV_LOAD = 1'b1;
        step();
        DIV_LOAD = 1'b0;
        n_run++;
        if (DIV_PENDING !== 1'b1) begin
            n_fail++;
            $display("FAIL div0_pending: got %b want 1", DIV_PENDING);
        end
        step();
        n_run++;
        if ({BAUD_TICK, DIV_PENDING} !== 2'b10) begin
            n_fail++;
            $display("FAIL div0_applied_at_wrap: tick/pend got %b want 10",
                     {BAUD_TICK, DIV_PENDING});
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if ({BAUD_TICK, BIT_TICK, BAUDOUT_CLK, DIV_PENDING} !== 4'b0000) bad++;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL div0_halted: %0d active cycles after +%0d want 0", bad, cyc - c);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frac();
        test_pending();
        test_sync_clr();
        test_en_restart();
        test_rst_mid();
        test_div1_div0();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
